// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles per operation.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [WIDTH-1:0] divisor, dvd, rem;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic             last;

    // One shift-add step; the carry of the add lands in the MSB after the shift.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] upper,
        input logic [WIDTH-1:0] mpl,
        input logic [WIDTH-1:0] mc
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, upper} + (mpl[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        return {sum, mpl[WIDTH-1:1]};
    endfunction

    // One restoring-division step; quotient bits shift into the dividend LSB.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] dsr
    );
        logic [WIDTH:0] sh;
        logic           q;
        sh = {r, d[WIDTH-1]};
        if (sh >= {1'b0, dsr}) begin
            sh = sh - {1'b0, dsr};
            q  = 1'b1;
        end else begin
            q  = 1'b0;
        end
        return {sh[WIDTH-1:0], d[WIDTH-2:0], q};
    endfunction

    always_comb begin
        mul_next = mul_step(acc, mplier, mcand);
        div_next = div_step(rem, dvd, divisor);
    end

    assign last  = (cnt == CNT_LAST);
    assign busy  = (state == S_MUL) || (state == S_DIV);
    assign done  = (state == S_DONE);
    assign stall = busy && start &&
                   ((Signal == F_MULTU) || (Signal == F_DIVU) ||
                    (Signal == F_MFHI)  || (Signal == F_MFLO));

    always_comb begin
        dataOut = '0;
        if (Signal == F_MFHI)
            dataOut = hi;
        else if (Signal == F_MFLO)
            dataOut = lo;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                next_state = S_IDLE;
                if (start) begin
                    if (Signal == F_MULTU)
                        next_state = S_MUL;
                    else if (Signal == F_DIVU)
                        next_state = (dataB == '0) ? S_DONE : S_DIV;
                end
            end
            S_MUL:   if (last) next_state = S_DONE;
            S_DIV:   if (last) next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath, counter and HI/LO; reset also aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            divisor <= '0;
            dvd     <= '0;
            rem     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && (Signal == F_MULTU)) begin
                        mcand  <= dataA;
                        mplier <= dataB;
                        acc    <= '0;
                        cnt    <= '0;
                    end else if (start && (Signal == F_DIVU)) begin
                        if (dataB != '0) begin
                            dvd     <= dataA;
                            divisor <= dataB;
                            rem     <= '0;
                            cnt     <= '0;
                        end else begin
                            hi <= dataA;
                            lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    {acc, mplier} <= mul_next;
                    cnt           <= cnt + CNT_ONE;
                    if (last) begin
                        hi <= mul_next[2*WIDTH-1:WIDTH];
                        lo <= mul_next[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    {rem, dvd} <= div_next;
                    cnt        <= cnt + CNT_ONE;
                    if (last) begin
                        hi <= div_next[2*WIDTH-1:WIDTH];
                        lo <= div_next[WIDTH-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized
// MULTU/DIVU traffic compared against plain-arithmetic expectations.
module tb_mul_div_unit;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] ADDU  = 6'b100001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB;
    logic [31:0] dataOut, hi, lo;
    logic        busy, done, stall;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .dataOut(dataOut),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: results and latency straight from the arithmetic definition.
    task automatic model(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output int rlat);
        logic [63:0] p;
        if (sig == MULTU) begin
            p = 64'(a) * 64'(b);
            rh = p[63:32]; rl = p[31:0]; rlat = 33;
        end else if (b == 0) begin
            rh = a; rl = 32'hFFFFFFFF; rlat = 1;
        end else begin
            rh = a % b; rl = a / b; rlat = 33;
        end
    endtask

    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; Signal = sig; dataA = a; dataB = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; Signal = 6'd0;
    endtask

    task automatic wait_done(input int first, output int lat, output int bc);
        lat = first; bc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        issue(MULTU, 32'hDEADBEEF, 32'h12345678);
        repeat (5) @(negedge clk);
        start = 1'b1; Signal = DIVU; dataA = 32'h55; dataB = 32'h3;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++;
        if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++;
        if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++;
        Signal = MFHI; #1;
        if (dataOut !== 32'd0) begin bad++; $display("FAIL reset_mfhi got=%h want=0", dataOut); end
        total++;
        Signal = MFLO; #1;
        if (dataOut !== 32'd0) begin bad++; $display("FAIL reset_mflo got=%h want=0", dataOut); end
        total++;
        Signal = 6'd0;
        reset = 1'b1;
        exp_hi = 0; exp_lo = 0;
        @(negedge clk);
    endtask

    task automatic test_mul_max;
        int lat, bc;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", bc); end
        total++;
        if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL mul_hi got=%h want=fffffffe", hi); end
        total++;
        if (lo !== 32'h00000001) begin bad++; $display("FAIL mul_lo got=%h want=00000001", lo); end
        total++;
        Signal = MFHI; #1;
        if (dataOut !== 32'hFFFFFFFE) begin bad++; $display("FAIL mul_mfhi got=%h want=fffffffe", dataOut); end
        total++;
        Signal = 6'd0;
        @(negedge clk);
        if (done !== 1'b0) begin bad++; $display("FAIL mul_done_width got=%0b want=0", done); end
        total++;
        exp_hi = 32'hFFFFFFFE; exp_lo = 32'h1;
    endtask

    task automatic test_div;
        int lat, bc;
        issue(DIVU, 32'd100, 32'd7);
        wait_done(1, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
        total++;
        if (lo !== 32'd14) begin bad++; $display("FAIL div_lo got=%0d want=14", lo); end
        total++;
        if (hi !== 32'd2) begin bad++; $display("FAIL div_hi got=%0d want=2", hi); end
        total++;
        Signal = MFLO; #1;
        if (dataOut !== 32'd14) begin bad++; $display("FAIL div_mflo got=%0d want=14", dataOut); end
        total++;
        Signal = 6'd0;
        @(negedge clk);
        exp_hi = 2; exp_lo = 14;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        issue(DIVU, 32'd5, 32'd0);
        if (busy !== 1'b0) begin bad++; $display("FAIL div0_busy got=%0b want=0", busy); end
        total++;
        wait_done(1, lat, bc);
        if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
        total++;
        if (hi !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h want=5", hi); end
        total++;
        if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo got=%h want=ffffffff", lo); end
        total++;
        @(negedge clk);
        exp_hi = 5; exp_lo = 32'hFFFFFFFF;
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        start = 1'b1; Signal = MULTU; dataA = 3; dataB = 4; #1;
        if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%0b want=0", stall); end
        total++;
        issue(MULTU, 32'd3, 32'd4);
        start = 1'b1; Signal = MFLO; #1;
        if (stall !== 1'b1) begin bad++; $display("FAIL busy_mflo_stall got=%0b want=1", stall); end
        total++;
        @(posedge clk); @(negedge clk);
        Signal = DIVU; dataA = 9; dataB = 2; #1;
        if (stall !== 1'b1) begin bad++; $display("FAIL busy_divu_stall got=%0b want=1", stall); end
        total++;
        @(posedge clk); @(negedge clk);
        Signal = ADDU; #1;
        if (stall !== 1'b0) begin bad++; $display("FAIL busy_addu_stall got=%0b want=0", stall); end
        total++;
        start = 1'b0; Signal = 6'd0;
        wait_done(3, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL ignored_start_latency got=%0d want=33", lat); end
        total++;
        if (lo !== 32'd12) begin bad++; $display("FAIL mul3x4_lo got=%0d want=12", lo); end
        total++;
        if (hi !== 32'd0) begin bad++; $display("FAIL mul3x4_hi got=%0d want=0", hi); end
        total++;
        issue(MULTU, 32'd6, 32'd7);
        wait_done(1, lat, bc);
        if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        total++;
        if (lo !== 32'd42) begin bad++; $display("FAIL b2b_lo got=%0d want=42", lo); end
        total++;
        @(negedge clk);
        exp_hi = 0; exp_lo = 42;
    endtask

    task automatic test_reset_abort;
        int pulses;
        issue(MULTU, 32'h1234, 32'h10);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++;
        if (hi !== 32'd0) begin bad++; $display("FAIL abort_hi got=%h want=0", hi); end
        total++;
        if (lo !== 32'd0) begin bad++; $display("FAIL abort_lo got=%h want=0", lo); end
        total++;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        if (pulses !== 0) begin bad++; $display("FAIL abort_done_pulses got=%0d want=0", pulses); end
        total++;
        exp_hi = 0; exp_lo = 0;
    endtask

    task automatic test_random;
        logic [5:0]  sig;
        logic [31:0] a, b, rh, rl;
        int          rlat, lat, bc;
        for (int n = 0; n < 24; n++) begin
            sig = ($urandom_range(0, 1) == 1) ? MULTU : DIVU;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(ADDU, $urandom, $urandom);
            if (done !== 1'b0) begin bad++; $display("FAIL rnd_nonop_done[%0d] got=%0b want=0", n, done); end
            total++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                bad++;
                $display("FAIL rnd_nonop_hilo[%0d] got=%h/%h want=%h/%h", n, hi, lo, exp_hi, exp_lo);
            end
            total++;
            model(sig, a, b, rh, rl, rlat);
            issue(sig, a, b);
            wait_done(1, lat, bc);
            if (lat !== rlat) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d want=%0d", n, lat, rlat); end
            total++;
            if (hi !== rh || lo !== rl) begin
                bad++;
                $display("FAIL rnd_result[%0d] op=%h a=%h b=%h got=%h/%h want=%h/%h", n, sig, a, b, hi, lo, rh, rl);
            end
            total++;
            Signal = MFHI; #1;
            if (dataOut !== rh) begin bad++; $display("FAIL rnd_mfhi[%0d] got=%h want=%h", n, dataOut, rh); end
            total++;
            Signal = 6'd0;
            exp_hi = rh; exp_lo = rl;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; Signal = 6'd0; dataA = 0; dataB = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_mul_max;
        test_div;
        test_div_zero;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
